bt_uart_rx_fifo: RTL and testbench

UART receiver front end for the Bluetooth (HC-06 class) serial link, sitting directly upstream of the AXI4-Lite Bluetooth register block.
- Oversamples the module's TX line at 16x and deframes 8N1 characters.
- Buffers received bytes in a show-ahead FIFO.
- Presents data, count and sticky error status for the register block to read and pop.

---
 rtl/bt_uart_rx_fifo_if.sv | 32 +++
 rtl/bt_uart_rx_fifo.sv | 191 +++++++++++++++++++
 tb/tb_bt_uart_rx_fifo.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/bt_uart_rx_fifo_if.sv
// Register-block side of the Bluetooth UART receiver.
//   rd_en      : pop strobe, one pop per cycle high
//   clr_err    : clears the overflow and frame_err sticky flags
//   rd_data    : FIFO head byte, valid while rd_valid is high
//   rd_valid   : FIFO non-empty
//   fifo_count : number of stored bytes
//   overflow   : sticky, a byte was dropped because the FIFO was full
//   frame_err  : sticky, a stop bit was sampled low
//   rx_busy    : deframer is inside a character
// master = register block, slave = receiver.
interface bt_uart_rx_fifo_if #(
    parameter int FIFO_DEPTH = 8
);
    logic                             rd_en;
    logic                             clr_err;
    logic [7:0]                       rd_data;
    logic                             rd_valid;
    logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count;
    logic                             overflow;
    logic                             frame_err;
    logic                             rx_busy;

    modport master (
        output rd_en, clr_err,
        input  rd_data, rd_valid, fifo_count, overflow, frame_err, rx_busy
    );

    modport slave (
        input  rd_en, clr_err,
        output rd_data, rd_valid, fifo_count, overflow, frame_err, rx_busy
    );
endinterface

// File: rtl/bt_uart_rx_fifo.sv
// UART receiver front end for the HC-06 Bluetooth serial link.
// Oversamples rx at 16x, deframes 8N1 characters and buffers them in a
// show-ahead FIFO read by the register block.
//   clock : system clock
//   reset : synchronous, active-high
//   rx    : asynchronous serial line, idle high
//   bus   : register-block side (pop, clear, data, count, status)
module bt_uart_rx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              rx,
    bt_uart_rx_fifo_if.slave  bus
);
    localparam int TICK_DIV = CLK_FREQ / (BAUD * 16);
    localparam int DIVW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW       = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    logic            rx_meta, rx_s;
    logic [DIVW-1:0] div_cnt;
    logic            tick;
    state_t          state;
    logic [3:0]      tcnt;
    logic [2:0]      bit_idx;
    logic [7:0]      shreg;
    logic            busy;
    logic            start_det, stop_tick, push, frame_bad;

    logic [7:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            full, pop, wr_en;
    logic            ovf, ferr;

    // Two-flop synchronizer, idles high like the line
    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_comb begin
        tick      = (div_cnt == DIVW'(TICK_DIV - 1));
        start_det = (state == IDLE) && !rx_s;
        stop_tick = (state == STOP) && tick && (tcnt == 4'd15);
        push      = stop_tick && rx_s;
        frame_bad = stop_tick && !rx_s;
    end

    // Restarting on the start edge puts every 8th tick mid-bit
    always_ff @(posedge clock) begin
        if (reset || start_det || tick) div_cnt <= '0;
        else                            div_cnt <= div_cnt + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            tcnt    <= '0;
            bit_idx <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state <= START;
                        busy  <= 1'b1;
                        tcnt  <= '0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tcnt == 4'd7) begin
                            tcnt <= '0;
                            if (rx_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state   <= DATA;
                                bit_idx <= '0;
                            end
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (tcnt == 4'd15) begin
                            tcnt  <= '0;
                            shreg <= {rx_s, shreg[7:1]};
                            if (bit_idx == 3'd7) state <= STOP;
                            else                 bit_idx <= bit_idx + 3'd1;
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        if (tcnt == 4'd15) begin
                            tcnt <= '0;
                            if (rx_s) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= WAIT_HIGH;
                            end
                        end else begin
                            tcnt <= tcnt + 4'd1;
                        end
                    end
                end
                WAIT_HIGH: begin
                    // A held-low line (break) must not restart deframing
                    if (rx_s) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        tcnt  <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    tcnt  <= '0;
                end
            endcase
        end
    end

    // A simultaneous pop frees the slot, so a push into a full FIFO still lands
    always_comb begin
        full  = (count == CW'(FIFO_DEPTH));
        pop   = bus.rd_en && (count != '0);
        wr_en = push && (!full || pop);
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= shreg;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            case ({wr_en, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle beats clr_err
    always_ff @(posedge clock) begin
        if (reset) begin
            ovf  <= 1'b0;
            ferr <= 1'b0;
        end else begin
            if (push && full && !pop) ovf <= 1'b1;
            else if (bus.clr_err)     ovf <= 1'b0;
            if (frame_bad)            ferr <= 1'b1;
            else if (bus.clr_err)     ferr <= 1'b0;
        end
    end

    // Head is forced to zero when empty so stale storage never shows
    always_comb begin
        bus.rd_data    = (count != '0) ? mem[rd_ptr] : 8'h00;
        bus.rd_valid   = (count != '0);
        bus.fifo_count = count;
        bus.overflow   = ovf;
        bus.frame_err  = ferr;
        bus.rx_busy    = busy;
    end
endmodule

// File: tb/tb_bt_uart_rx_fifo.sv
// Scoreboard bench for bt_uart_rx_fifo: serial frames are driven on rx,
// expected bytes are queued, and a monitor compares every popped byte.
module tb_bt_uart_rx_fifo;
    localparam int CLK_FREQ = 1_600_000;
    localparam int BAUD     = 10_000;
    localparam int DEPTH    = 8;
    localparam int BIT_CYC  = 160;
    // Stop-bit sample edge counted from the cycle rx falls: 2 sync + 1 detect
    // + 8 ticks to mid start + 9 bits * 16 ticks, minus the setup cycle
    localparam int PUSH_LEAD = 1522;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rx    = 1'b1;

    int vectors     = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    bt_uart_rx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus();

    bt_uart_rx_fifo #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD      (BAUD),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clock(clock),
        .reset(reset),
        .rx   (rx),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop_bit);
        rx = 1'b0;
        step(BIT_CYC);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            step(BIT_CYC);
        end
        rx = stop_bit;
        step(BIT_CYC);
        rx = 1'b1;
    endtask

    task automatic pop_n(input int n);
        bus.rd_en = 1'b1;
        step(n);
        bus.rd_en = 1'b0;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rd_data"},    bus.rd_data,    8'h00);
        check({tag, "_rd_valid"},   bus.rd_valid,   0);
        check({tag, "_fifo_count"}, bus.fifo_count, 0);
        check({tag, "_overflow"},   bus.overflow,   0);
        check({tag, "_frame_err"},  bus.frame_err,  0);
        check({tag, "_rx_busy"},    bus.rx_busy,    0);
    endtask

    // Monitor: every accepted pop is compared against the queue head
    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clock);
            if (bus.rd_en && bus.rd_valid && !reset) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL pop_unexpected: got %02h, expected no byte", bus.rd_data);
                end else begin
                    exp_b = exp_q.pop_front();
                    if (bus.rd_data !== exp_b) begin
                        miscompares++;
                        $display("FAIL pop_data: got %02h, expected %02h", bus.rd_data, exp_b);
                    end
                end
            end
        end
    end

    initial begin
        bus.rd_en   = 1'b0;
        bus.clr_err = 1'b0;

        step(3);
        check_reset_values("reset");
        reset = 1'b0;
        step(5);

        // Single clean character, then one pop
        exp_q.push_back(8'h55);
        send_byte(8'h55, 1'b1);
        check("t55_valid", bus.rd_valid,   1);
        check("t55_data",  bus.rd_data,    8'h55);
        check("t55_count", bus.fifo_count, 1);
        pop_n(1);
        check("t55_count_after_pop", bus.fifo_count, 0);
        check("t55_valid_after_pop", bus.rd_valid,   0);

        // Short low glitch is rejected at mid start bit
        rx = 1'b0;
        step(50);
        rx = 1'b1;
        check("glitch_busy_during", bus.rx_busy, 1);
        step(150);
        check("glitch_busy_after", bus.rx_busy,    0);
        check("glitch_count",      bus.fifo_count, 0);
        check("glitch_frame_err",  bus.frame_err,  0);

        // Framing error, then recovery
        send_byte(8'hA3, 1'b0);
        step(20);
        check("ferr_flag",  bus.frame_err,  1);
        check("ferr_count", bus.fifo_count, 0);
        check("ferr_busy",  bus.rx_busy,    0);
        exp_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b1);
        check("ferr_next_count", bus.fifo_count, 1);
        check("ferr_next_data",  bus.rd_data,    8'h3C);
        check("ferr_sticky",     bus.frame_err,  1);
        pop_n(1);
        bus.clr_err = 1'b1;
        step(1);
        bus.clr_err = 1'b0;
        check("ferr_cleared", bus.frame_err, 0);

        // Full FIFO with a pop landing on the push cycle
        for (int b = 8'h61; b <= 8'h68; b++) begin
            exp_q.push_back(8'(b));
            send_byte(8'(b), 1'b1);
        end
        check("full_count",    bus.fifo_count, 8);
        check("full_overflow", bus.overflow,   0);
        exp_q.push_back(8'h77);
        fork
            send_byte(8'h77, 1'b1);
            begin
                step(PUSH_LEAD);
                bus.rd_en = 1'b1;
                step(1);
                bus.rd_en = 1'b0;
            end
        join
        check("pushpop_count",    bus.fifo_count, 8);
        check("pushpop_overflow", bus.overflow,   0);
        pop_n(8);
        check("pushpop_drained", bus.fifo_count, 0);

        // Overflow: ninth byte dropped
        for (int b = 1; b <= 9; b++) begin
            if (b <= 8) exp_q.push_back(8'(b));
            send_byte(8'(b), 1'b1);
        end
        check("ovf_count", bus.fifo_count, 8);
        check("ovf_flag",  bus.overflow,   1);
        check("ovf_head",  bus.rd_data,    8'h01);
        pop_n(8);
        check("ovf_drained_count", bus.fifo_count, 0);
        check("ovf_drained_valid", bus.rd_valid,   0);
        check("ovf_sticky",        bus.overflow,   1);

        // Reset in DATA bit 4 with a byte stored and overflow still set
        send_byte(8'h99, 1'b1);
        check("prereset_count", bus.fifo_count, 1);
        fork
            send_byte(8'hF0, 1'b1);
            begin
                step(850);
                check("prereset_busy", bus.rx_busy, 1);
                reset = 1'b1;
                step(1);
                reset = 1'b0;
                check_reset_values("midreset");
            end
        join
        step(10);
        check("postreset_busy",  bus.rx_busy,    0);
        check("postreset_count", bus.fifo_count, 0);
        exp_q.push_back(8'h12);
        send_byte(8'h12, 1'b1);
        check("t12_count", bus.fifo_count, 1);
        check("t12_data",  bus.rd_data,    8'h12);
        pop_n(1);
        step(2);

        check("scoreboard_left", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
